cpu6_bootload: RTL and testbench

//  Boot loader upstream of the unified 2-port program/data RAM and cpu6_core.

---
 rtl/cpu6_bootload.sv | 127 ++++++++++++
 tb/tb_cpu6_bootload.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu6_bootload.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into RAM words, checks an
// XOR checksum and releases core reset. Optional inter-byte timeout under CPU6_BOOT_TIMEOUT_EN.
module cpu6_bootload #(
    parameter int unsigned ADDR_W         = 11,
    parameter int unsigned BASE_ADDR      = 0,
    parameter int unsigned MAX_WORDS      = 2048,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    output logic              ram_we,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {StLen, StData, StCsum, StDone, StErr} state_t;

    state_t            state;
    logic [1:0]        byte_cnt;
    logic [23:0]       shift;
    logic [CNT_W-1:0]  nwords;
    logic [CNT_W-1:0]  word_idx;
    logic [7:0]        csum;
    logic              accept;
    logic [31:0]       full_word;

`ifdef CPU6_BOOT_TIMEOUT_EN
    logic [31:0]       idle_cnt;
    logic              started;
`endif

    assign accept    = rx_valid & rx_ready;
    // Earlier bytes sit in shift; the current byte completes the 32-bit LE value.
    assign full_word = {rx_data, shift};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= StLen;
            byte_cnt   <= 2'd0;
            shift      <= 24'd0;
            nwords     <= '0;
            word_idx   <= '0;
            csum       <= 8'd0;
            rx_ready   <= 1'b1;
            ram_addr   <= ADDR_W'(BASE_ADDR);
            ram_wdata  <= 32'd0;
            ram_we     <= 1'b0;
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef CPU6_BOOT_TIMEOUT_EN
            idle_cnt   <= 32'd0;
            started    <= 1'b0;
`endif
        end else begin
            ram_we <= 1'b0;
            if (accept) begin
                byte_cnt <= byte_cnt + 2'd1;
                shift    <= {rx_data, shift[23:8]};
                case (state)
                    StLen: begin
                        if (byte_cnt == 2'd3) begin
                            // Full 32-bit compare so large lengths cannot alias into range.
                            if (full_word > 32'(MAX_WORDS)) begin
                                state    <= StErr;
                                error    <= 1'b1;
                                rx_ready <= 1'b0;
                            end else if (full_word == 32'd0) begin
                                state <= StCsum;
                            end else begin
                                nwords <= full_word[CNT_W-1:0];
                                state  <= StData;
                            end
                        end
                    end
                    StData: begin
                        csum <= csum ^ rx_data;
                        if (byte_cnt == 2'd3) begin
                            ram_we    <= 1'b1;
                            ram_wdata <= full_word;
                            ram_addr  <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_idx);
                            word_idx  <= word_idx + 1'b1;
                            if (word_idx == nwords - 1'b1) begin
                                state <= StCsum;
                            end
                        end
                    end
                    StCsum: begin
                        rx_ready <= 1'b0;
                        if (rx_data == csum) begin
                            state      <= StDone;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state <= StErr;
                            error <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
`ifdef CPU6_BOOT_TIMEOUT_EN
            if (accept) begin
                idle_cnt <= 32'd0;
                started  <= 1'b1;
            end else if (started && (state == StLen || state == StData || state == StCsum)) begin
                if (idle_cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    state    <= StErr;
                    error    <= 1'b1;
                    rx_ready <= 1'b0;
                end else begin
                    idle_cnt <= idle_cnt + 32'd1;
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_cpu6_bootload.sv
// Self-checking bench for cpu6_bootload: directed frames plus random frames checked against a
// queue-based reference of expected RAM writes and final status.
module tb_cpu6_bootload;

    localparam int unsigned AW   = 12;
    localparam int unsigned BASE = 16;
    localparam int unsigned MAXW = 2048;
    localparam int unsigned TO   = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic          core_reset;
    logic          done;
    logic          error;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] wr_addr[$];
    logic [31:0]   wr_data[$];
    logic [31:0]   words[$];
    logic [7:0]    frame[$];

    always #5 clk = ~clk;

    cpu6_bootload #(
        .ADDR_W(AW), .BASE_ADDR(BASE), .MAX_WORDS(MAXW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .core_reset(core_reset), .done(done), .error(error)
    );

    always @(negedge clk) begin
        if (ram_we === 1'b1) begin
            wr_addr.push_back(ram_addr);
            wr_data.push_back(ram_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    // Reference frame: 4 LE length bytes, LE payload words, XOR of payload bytes.
    task automatic build_frame(input bit corrupt);
        logic [31:0] n;
        logic [7:0]  c;
        logic [31:0] w;
        n = 32'(words.size());
        c = 8'h00;
        frame.delete();
        for (int k = 0; k < 4; k++) frame.push_back(n[8*k +: 8]);
        for (int i = 0; i < words.size(); i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
                c = c ^ w[8*k +: 8];
                frame.push_back(w[8*k +: 8]);
            end
        end
        frame.push_back(corrupt ? ~c : c);
    endtask

    task automatic send_frame(input int maxgap);
        for (int i = 0; i < frame.size(); i++) begin
            repeat ($urandom_range(maxgap, 0)) @(negedge clk);
            send_byte(frame[i]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        int n;
        chk({tag, "_wcnt"}, 32'(wr_addr.size()), 32'(words.size()));
        n = (wr_addr.size() < words.size()) ? wr_addr.size() : words.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_addr"}, 32'(wr_addr[i]), 32'(BASE + i));
            chk({tag, "_data"}, wr_data[i], words[i]);
        end
    endtask

    task automatic check_status(input string tag, input bit ok);
        chk({tag, "_done"}, 32'(done), 32'(ok));
        chk({tag, "_error"}, 32'(error), 32'(!ok));
        chk({tag, "_core_reset"}, 32'(core_reset), 32'(!ok));
        chk({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    endtask

    initial begin
        bit corrupt;
        int n;

        do_reset();
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'(BASE));

        // Two-word directed frame, good then corrupted checksum.
        words = '{32'h1234_5678, 32'hDEAD_BEEF};
        build_frame(1'b0);
        send_frame(2);
        check_writes("two_good");
        check_status("two_good", 1'b1);

        do_reset();
        build_frame(1'b1);
        send_frame(1);
        check_writes("two_bad");
        check_status("two_bad", 1'b0);

        // Length 2049 rejected immediately.
        do_reset();
        send_byte(8'h01); send_byte(8'h08); send_byte(8'h00); send_byte(8'h00);
        chk("len2049_error", 32'(error), 32'd1);
        chk("len2049_ready", 32'(rx_ready), 32'd0);
        send_byte(8'h55);
        repeat (2) @(negedge clk);
        chk("len2049_wcnt", 32'(wr_addr.size()), 32'd0);
        chk("len2049_done", 32'(done), 32'd0);

        // 64K length must not be truncated into range.
        do_reset();
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h01); send_byte(8'h00);
        chk("len64k_error", 32'(error), 32'd1);

        // Maximum image, back-to-back bytes.
        do_reset();
        words.delete();
        for (int i = 0; i < MAXW; i++) words.push_back($urandom);
        build_frame(1'b0);
        send_frame(0);
        check_writes("max");
        check_status("max", 1'b1);

        // Empty image; later bytes ignored.
        do_reset();
        words.delete();
        build_frame(1'b0);
        send_frame(1);
        check_writes("empty");
        check_status("empty", 1'b1);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
        repeat (2) @(negedge clk);
        chk("after_done_wcnt", 32'(wr_addr.size()), 32'd0);
        chk("after_done_done", 32'(done), 32'd1);

        // Async reset mid-payload, then a clean 1-word frame.
        do_reset();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_core_reset", 32'(core_reset), 32'd1);
        chk("midrst_rx_ready", 32'(rx_ready), 32'd1);
        chk("midrst_addr", 32'(ram_addr), 32'(BASE));
        do_reset();
        words = '{32'hCAFE_F00D};
        build_frame(1'b0);
        send_frame(2);
        check_writes("midrst");
        check_status("midrst", 1'b1);

        // Random frames.
        for (int t = 0; t < 12; t++) begin
            do_reset();
            words.delete();
            n = $urandom_range(9, 1);
            for (int i = 0; i < n; i++) words.push_back($urandom);
            corrupt = ($urandom_range(3, 0) == 0);
            build_frame(corrupt);
            send_frame(3);
            check_writes("rand");
            check_status("rand", !corrupt);
        end

`ifdef CPU6_BOOT_TIMEOUT_EN
        // No timeout before the first byte.
        do_reset();
        repeat (3 * TO) @(negedge clk);
        chk("to_idle_error", 32'(error), 32'd0);
        chk("to_idle_ready", 32'(rx_ready), 32'd1);

        // Stall of TO-1 cycles mid-payload is tolerated.
        words = '{32'h0BAD_F00D};
        build_frame(1'b0);
        for (int i = 0; i < frame.size(); i++) begin
            if (i == 6) repeat (TO - 1) @(negedge clk);
            send_byte(frame[i]);
        end
        repeat (2) @(negedge clk);
        check_writes("to_15");
        check_status("to_15", 1'b1);

        // Stall of TO cycles mid-payload errors out.
        do_reset();
        for (int i = 0; i < frame.size(); i++) begin
            if (i == 6) repeat (TO) @(negedge clk);
            send_byte(frame[i]);
        end
        repeat (2) @(negedge clk);
        chk("to_16_wcnt", 32'(wr_addr.size()), 32'd0);
        check_status("to_16", 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
